// File: rtl/lcd_clk_ctrl.sv
// LCD pixel-clock reconfiguration sequencer: accepts a new panel ID, blanks the panel at a
// frame boundary, switches ID_lcd while lcd_en is low, waits for clk_div to settle, re-enables.
module lcd_clk_ctrl #(
    parameter logic [15:0] DEFAULT_ID  = 16'd0,
    parameter bit          WAIT_FRAME  = 1'b1,
    parameter int unsigned TIMEOUT_CYC = 1_000_000,
    parameter int unsigned QUIET_CYC   = 16,
    parameter int unsigned SETTLE_CYC  = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic [15:0] req_id,
    output logic        req_ready,
    input  logic        frame_end,
    output logic [15:0] ID_lcd,
    output logic        lcd_en,
    output logic        cfg_done,
    output logic        cfg_err,
    output logic        busy
);

    localparam int unsigned CNT_MAX0 = (TIMEOUT_CYC > QUIET_CYC) ? TIMEOUT_CYC : QUIET_CYC;
    localparam int unsigned CNT_MAX  = (CNT_MAX0 > SETTLE_CYC) ? CNT_MAX0 : SETTLE_CYC;
    localparam int unsigned CNT_W    = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] QT_LAST = CNT_W'(QUIET_CYC - 1);
    localparam logic [CNT_W-1:0] ST_LAST = CNT_W'(SETTLE_CYC - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_DRAIN  = 3'd1;
    localparam logic [2:0] S_QUIET  = 3'd2;
    localparam logic [2:0] S_SWITCH = 3'd3;
    localparam logic [2:0] S_SETTLE = 3'd4;
    localparam logic [2:0] S_ENABLE = 3'd5;

    logic [2:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [15:0]      r_id;
    logic [15:0]      r_pend_id;
    logic             r_lcd_en;
    logic             r_done;
    logic             r_err;
    logic             r_err_pend;
    logic             r_boot;

    logic [2:0]       w_state_nxt;
    logic             w_accept;
    logic             w_same;
    logic             w_timeout;
    logic             w_map_ok;
    logic [15:0]      w_map_id;
    logic             w_counting;
    logic             w_enter;

    // Only IDs that clk_div decodes are passed through; anything else falls back to 0.
    assign w_map_ok = (req_id == 16'd0) || (req_id == 16'd1) ||
                      (req_id == 16'd2) || (req_id == 16'd5);
    assign w_map_id = w_map_ok ? req_id : 16'd0;

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (req_valid) begin
                    w_accept = 1'b1;
                    if (w_map_id != r_id) begin
                        w_state_nxt = WAIT_FRAME ? S_DRAIN : S_QUIET;
                    end
                end
            end
            S_DRAIN: begin
                // frame_end takes priority over a simultaneous timeout
                if (frame_end) begin
                    w_state_nxt = S_QUIET;
                end else if (r_cnt == TO_LAST) begin
                    w_state_nxt = S_QUIET;
                    w_timeout   = 1'b1;
                end
            end
            S_QUIET:  if (r_cnt == QT_LAST) w_state_nxt = S_SWITCH;
            S_SWITCH: w_state_nxt = S_SETTLE;
            S_SETTLE: if (r_cnt == ST_LAST) w_state_nxt = S_ENABLE;
            S_ENABLE: w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_SETTLE;
        endcase
    end

    assign w_same     = w_accept && (w_map_id == r_id);
    assign w_enter    = (w_state_nxt != r_state);
    assign w_counting = (r_state == S_DRAIN) || (r_state == S_QUIET) || (r_state == S_SETTLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_SETTLE;
            r_cnt      <= '0;
            r_id       <= DEFAULT_ID;
            r_pend_id  <= DEFAULT_ID;
            r_lcd_en   <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_err_pend <= 1'b0;
            r_boot     <= 1'b1;
        end else begin
            r_state <= w_state_nxt;

            if (w_enter) begin
                r_cnt <= '0;
            end else if (w_counting && (r_cnt != {CNT_W{1'b1}})) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end

            if (w_accept) begin
                r_pend_id  <= w_map_id;
                r_err_pend <= !w_map_ok;
            end else if (w_timeout) begin
                r_err_pend <= 1'b1;
            end

            r_done <= w_same || ((r_state == S_ENABLE) && !r_boot);

            if (w_same) begin
                r_err <= !w_map_ok;
            end

            if ((w_state_nxt == S_QUIET) && (r_state != S_QUIET)) begin
                r_lcd_en <= 1'b0;
            end

            if (r_state == S_SWITCH) begin
                r_id <= r_pend_id;
            end

            // The boot pass through ENABLE re-enables the panel but reports nothing.
            if (r_state == S_ENABLE) begin
                r_lcd_en <= 1'b1;
                r_boot   <= 1'b0;
                if (!r_boot) begin
                    r_err <= r_err_pend;
                end
            end
        end
    end

    assign req_ready = (r_state == S_IDLE);
    assign busy      = (r_state != S_IDLE);
    assign ID_lcd    = r_id;
    assign lcd_en    = r_lcd_en;
    assign cfg_done  = r_done;
    assign cfg_err   = r_err;

endmodule

// File: tb/tb_lcd_clk_ctrl.sv
// Bench for lcd_clk_ctrl: three instances (no frame wait, frame wait, short timeout) checked
// every cycle against an event-schedule model, plus hand-computed literal expectations.
module tb_lcd_clk_ctrl;

    localparam int unsigned Q = 16;
    localparam int unsigned S = 64;
    localparam bit          WF [3] = '{1'b0, 1'b1, 1'b1};
    localparam int unsigned TO [3] = '{1_000_000, 1_000_000, 100};

    logic        clk;
    logic        rst_n;
    logic        req_valid [3];
    logic [15:0] req_id    [3];
    logic        frame_end [3];
    logic        req_ready [3];
    logic [15:0] id_lcd    [3];
    logic        lcd_en    [3];
    logic        cfg_done  [3];
    logic        cfg_err   [3];
    logic        busy      [3];

    int n_checks = 0;
    int n_fail   = 0;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        lcd_clk_ctrl #(
            .DEFAULT_ID (16'd0),
            .WAIT_FRAME (WF[g]),
            .TIMEOUT_CYC(TO[g]),
            .QUIET_CYC  (Q),
            .SETTLE_CYC (S)
        ) u_dut (
            .clk      (clk),
            .rst_n    (rst_n),
            .req_valid(req_valid[g]),
            .req_id   (req_id[g]),
            .req_ready(req_ready[g]),
            .frame_end(frame_end[g]),
            .ID_lcd   (id_lcd[g]),
            .lcd_en   (lcd_en[g]),
            .cfg_done (cfg_done[g]),
            .cfg_err  (cfg_err[g]),
            .busy     (busy[g])
        );
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Model: each transaction becomes a schedule of edge numbers (blank, switch, enable).
    int          cyc;
    bit          m_drain [3];
    int          m_acc   [3];
    int          m_sw    [3];
    int          m_en    [3];
    logic [15:0] m_id    [3];
    logic [15:0] m_pid   [3];
    bit          m_lcd   [3];
    bit          m_done  [3];
    bit          m_err   [3];
    bit          m_busy  [3];
    bit          m_perr  [3];
    bit          m_boot  [3];

    function automatic bit legal(input logic [15:0] id);
        return (id == 16'd0) || (id == 16'd1) || (id == 16'd2) || (id == 16'd5);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc = 0;
            for (int k = 0; k < 3; k++) begin
                m_id[k]    = 16'd0;
                m_pid[k]   = 16'd0;
                m_lcd[k]   = 1'b0;
                m_done[k]  = 1'b0;
                m_err[k]   = 1'b0;
                m_busy[k]  = 1'b1;
                m_boot[k]  = 1'b1;
                m_drain[k] = 1'b0;
                m_perr[k]  = 1'b0;
                m_acc[k]   = 0;
                m_sw[k]    = -1;
                m_en[k]    = S + 1;
            end
        end else begin
            cyc++;
            for (int k = 0; k < 3; k++) begin
                m_done[k] = 1'b0;
                if (!m_busy[k]) begin
                    if (req_valid[k]) begin
                        logic [15:0] mid;
                        mid = legal(req_id[k]) ? req_id[k] : 16'd0;
                        if (mid == m_id[k]) begin
                            m_done[k] = 1'b1;
                            m_err[k]  = !legal(req_id[k]);
                        end else begin
                            m_busy[k] = 1'b1;
                            m_pid[k]  = mid;
                            m_perr[k] = !legal(req_id[k]);
                            m_sw[k]   = -1;
                            m_en[k]   = -1;
                            if (WF[k]) begin
                                m_drain[k] = 1'b1;
                                m_acc[k]   = cyc;
                            end else begin
                                m_lcd[k] = 1'b0;
                                m_sw[k]  = cyc + Q + 1;
                                m_en[k]  = cyc + Q + S + 2;
                            end
                        end
                    end
                end else begin
                    if (m_drain[k] && (frame_end[k] || cyc == m_acc[k] + int'(TO[k]))) begin
                        if (!frame_end[k]) m_perr[k] = 1'b1;
                        m_drain[k] = 1'b0;
                        m_lcd[k]   = 1'b0;
                        m_sw[k]    = cyc + Q + 1;
                        m_en[k]    = cyc + Q + S + 2;
                    end
                    if (cyc == m_sw[k]) m_id[k] = m_pid[k];
                    if (cyc == m_en[k]) begin
                        m_lcd[k]  = 1'b1;
                        m_busy[k] = 1'b0;
                        if (!m_boot[k]) begin
                            m_done[k] = 1'b1;
                            m_err[k]  = m_perr[k];
                        end
                        m_boot[k] = 1'b0;
                    end
                end
            end
        end
    end

    logic [20:0] cmp_act;
    logic [20:0] cmp_exp;

    always @(posedge clk) begin
        #1;
        for (int k = 0; k < 3; k++) begin
            cmp_act = {id_lcd[k], lcd_en[k], cfg_done[k], cfg_err[k], busy[k], req_ready[k]};
            cmp_exp = {m_id[k], m_lcd[k], m_done[k], m_err[k], m_busy[k], !m_busy[k]};
            chk($sformatf("dut%0d_outputs@%0d", k, cyc), 32'(cmp_act), 32'(cmp_exp));
        end
    end

    task automatic at_edge(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input int k, input logic [15:0] id, output int acc);
        int n;
        n = 0;
        @(negedge clk);
        req_valid[k] = 1'b1;
        req_id[k]    = id;
        while (req_ready[k] !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("dut%0d_accept_in_time", k), 32'(n < 2000), 32'd1);
        @(posedge clk);
        #1;
        acc = cyc;
        @(negedge clk);
        req_valid[k] = 1'b0;
    endtask

    task automatic pulse_frame_end(input int k, input int edge_no);
        at_edge(edge_no - 1);
        @(negedge clk);
        frame_end[k] = 1'b1;
        @(negedge clk);
        frame_end[k] = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1);
    end

    initial begin
        int acc;
        rst_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            req_valid[k] = 1'b0;
            req_id[k]    = 16'd0;
            frame_end[k] = 1'b0;
        end
        repeat (3) @(negedge clk);
        chk("reset_busy", 32'(busy[0]), 32'd1);
        chk("reset_ready", 32'(req_ready[0]), 32'd0);
        chk("reset_lcd_en", 32'(lcd_en[0]), 32'd0);
        rst_n = 1'b1;

        // Boot: 64 settle + 1 enable cycle with lcd_en low
        at_edge(64);
        chk("boot_lcd_en_low_64", 32'(lcd_en[0]), 32'd0);
        at_edge(65);
        chk("boot_lcd_en_65", 32'(lcd_en[0]), 32'd1);
        chk("boot_busy_65", 32'(busy[0]), 32'd0);
        chk("boot_no_done", 32'(cfg_done[0]), 32'd0);

        // No frame wait, ID 1
        send(0, 16'd1, acc);
        at_edge(acc + 1);
        chk("nf_lcd_en_low", 32'(lcd_en[0]), 32'd0);
        at_edge(acc + 16);
        chk("nf_id_before_switch", 32'(id_lcd[0]), 32'd0);
        at_edge(acc + 17);
        chk("nf_id_switched", 32'(id_lcd[0]), 32'd1);
        at_edge(acc + 81);
        chk("nf_lcd_en_81", 32'(lcd_en[0]), 32'd0);
        at_edge(acc + 82);
        chk("nf_lcd_en_82", 32'(lcd_en[0]), 32'd1);
        chk("nf_done_82", 32'(cfg_done[0]), 32'd1);
        chk("nf_err_82", 32'(cfg_err[0]), 32'd0);

        // Frame wait, ID 2, frame_end at +500
        send(1, 16'd2, acc);
        pulse_frame_end(1, acc + 500);
        chk("fw_lcd_en_low_500", 32'(lcd_en[1]), 32'd0);
        at_edge(acc + 582);
        chk("fw_id_582", 32'(id_lcd[1]), 32'd2);
        chk("fw_done_582", 32'(cfg_done[1]), 32'd1);

        // Illegal ID maps to 0 with error; then a same-ID request
        send(0, 16'h7777, acc);
        at_edge(acc + 82);
        chk("bad_id_lcd", 32'(id_lcd[0]), 32'd0);
        chk("bad_id_err", 32'(cfg_err[0]), 32'd1);
        send(0, 16'd0, acc);
        chk("same_done", 32'(cfg_done[0]), 32'd1);
        chk("same_err", 32'(cfg_err[0]), 32'd0);
        chk("same_lcd_en", 32'(lcd_en[0]), 32'd1);
        at_edge(acc + 1);
        chk("same_done_once", 32'(cfg_done[0]), 32'd0);

        // frame_end outside DRAIN is ignored; then timeout paths
        pulse_frame_end(2, cyc + 2);
        send(2, 16'd1, acc);
        at_edge(acc + 99);
        chk("to_lcd_en_99", 32'(lcd_en[2]), 32'd1);
        at_edge(acc + 100);
        chk("to_lcd_en_100", 32'(lcd_en[2]), 32'd0);
        at_edge(acc + 182);
        chk("to_err", 32'(cfg_err[2]), 32'd1);
        chk("to_id", 32'(id_lcd[2]), 32'd1);
        send(2, 16'd2, acc);
        pulse_frame_end(2, acc + 100);
        at_edge(acc + 182);
        chk("tie_err", 32'(cfg_err[2]), 32'd0);
        chk("tie_done", 32'(cfg_done[2]), 32'd1);

        // Reset mid-SETTLE with a request held high throughout
        send(0, 16'd5, acc);
        at_edge(acc + 40);
        @(negedge clk);
        req_valid[0] = 1'b1;
        req_id[0]    = 16'd2;
        rst_n        = 1'b0;
        #1;
        chk("mid_rst_lcd_en", 32'(lcd_en[0]), 32'd0);
        chk("mid_rst_id", 32'(id_lcd[0]), 32'd0);
        chk("mid_rst_busy", 32'(busy[0]), 32'd1);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        at_edge(64);
        chk("reboot_not_ready_64", 32'(req_ready[0]), 32'd0);
        at_edge(65);
        chk("reboot_ready_65", 32'(req_ready[0]), 32'd1);
        at_edge(66);
        chk("reboot_accept_66", 32'(busy[0]), 32'd1);
        at_edge(66 + 82);
        chk("reboot_id", 32'(id_lcd[0]), 32'd2);
        chk("reboot_done", 32'(cfg_done[0]), 32'd1);
        @(negedge clk);
        req_valid[0] = 1'b0;

        repeat (5) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
